// File: rtl/fifo_register.sv
// fifo_register: single-clock register-based FIFO with registered read data and count-derived flags
// Ports: clock/aclr (async active-high clear), wrreq/data write side, rdreq/q read side,
//        rdempty (0 words), wrfull (DEPTH words), usedw (word count 0..DEPTH).
module fifo_register #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             rdempty,
  output logic             wrfull,
  output logic [AW:0]      usedw
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_usedw;
  logic [WIDTH-1:0] r_q;
  logic             w_wr_ok;
  logic             w_rd_ok;
  assign rdempty = r_usedw == '0;
  assign wrfull  = r_usedw == (AW+1)'(DEPTH);
  // a full FIFO drops the write even when a read frees a slot on the same edge
  assign w_wr_ok = wrreq & ~wrfull & ~aclr;
  assign w_rd_ok = rdreq & ~rdempty & ~aclr;
  assign q       = r_q;
  assign usedw   = r_usedw;
  // storage carries no reset; stale words are unreachable once the pointers clear
  always_ff @(posedge clock)
    if (w_wr_ok) r_mem[r_wp] <= data;
  always_ff @(posedge clock or posedge aclr)
    if (aclr) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_usedw <= '0;
      r_q     <= '0;
    end else begin
      r_wp    <= r_wp + AW'(w_wr_ok);
      r_rp    <= r_rp + AW'(w_rd_ok);
      r_usedw <= r_usedw + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);
      if (w_rd_ok) r_q <= r_mem[r_rp];
    end
endmodule

// File: tb/tb_fifo_register.sv
// tb_fifo_register: directed self-checking bench for fifo_register (WIDTH=4, DEPTH=16)
module tb_fifo_register;
  logic       clock = 1'b0;
  logic       aclr;
  logic       wrreq;
  logic [3:0] data;
  logic       rdreq;
  logic [3:0] q;
  logic       rdempty;
  logic       wrfull;
  logic [4:0] usedw;
  int compared = 0;
  int mismatched = 0;

  fifo_register #(.WIDTH(4), .DEPTH(16)) dut (
    .clock(clock), .aclr(aclr), .wrreq(wrreq), .data(data), .rdreq(rdreq),
    .q(q), .rdempty(rdempty), .wrfull(wrfull), .usedw(usedw)
  );

  always #5 clock = ~clock;

  task automatic test_reset;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      compared++; if (q !== 4'h0) begin mismatched++; $display("FAIL reset_q got=%h want=0", q); end
      compared++; if (rdempty !== 1'b1) begin mismatched++; $display("FAIL reset_rdempty got=%b want=1", rdempty); end
      compared++; if (wrfull !== 1'b0) begin mismatched++; $display("FAIL reset_wrfull got=%b want=0", wrfull); end
      compared++; if (usedw !== 5'd0) begin mismatched++; $display("FAIL reset_usedw got=%0d want=0", usedw); end
    end
  endtask

  task automatic test_streaming;
    aclr = 1'b0; wrreq = 1'b1; rdreq = 1'b1; data = 4'h0;
    @(negedge clock);
    compared++; if (usedw !== 5'd1) begin mismatched++; $display("FAIL stream_first_usedw got=%0d want=1", usedw); end
    compared++; if (rdempty !== 1'b0) begin mismatched++; $display("FAIL stream_first_rdempty got=%b want=0", rdempty); end
    compared++; if (q !== 4'h0) begin mismatched++; $display("FAIL stream_first_q got=%h want=0", q); end
    for (int k = 1; k <= 6; k++) begin
      data = 4'(k);
      @(negedge clock);
      compared++; if (q !== 4'(k - 1)) begin mismatched++; $display("FAIL stream_q[%0d] got=%h want=%h", k, q, 4'(k - 1)); end
      compared++; if (usedw !== 5'd1) begin mismatched++; $display("FAIL stream_usedw[%0d] got=%0d want=1", k, usedw); end
      compared++; if (rdempty !== 1'b0) begin mismatched++; $display("FAIL stream_rdempty[%0d] got=%b want=0", k, rdempty); end
    end
    wrreq = 1'b0;
    @(negedge clock);
    compared++; if (q !== 4'h6) begin mismatched++; $display("FAIL stream_drain_q got=%h want=6", q); end
    compared++; if (rdempty !== 1'b1) begin mismatched++; $display("FAIL stream_drain_rdempty got=%b want=1", rdempty); end
    rdreq = 1'b0;
  endtask

  task automatic test_fill;
    wrreq = 1'b1; rdreq = 1'b0;
    for (int i = 0; i < 16; i++) begin
      data = 4'(i);
      @(negedge clock);
      if (i == 14) begin
        compared++; if (wrfull !== 1'b0) begin mismatched++; $display("FAIL fill15_wrfull got=%b want=0", wrfull); end
        compared++; if (usedw !== 5'd15) begin mismatched++; $display("FAIL fill15_usedw got=%0d want=15", usedw); end
      end
    end
    compared++; if (wrfull !== 1'b1) begin mismatched++; $display("FAIL fill16_wrfull got=%b want=1", wrfull); end
    compared++; if (usedw !== 5'd16) begin mismatched++; $display("FAIL fill16_usedw got=%0d want=16", usedw); end
    data = 4'h5;
    @(negedge clock);
    compared++; if (usedw !== 5'd16) begin mismatched++; $display("FAIL fill_drop_usedw got=%0d want=16", usedw); end
    wrreq = 1'b0; rdreq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      compared++; if (q !== 4'(i)) begin mismatched++; $display("FAIL fill_read_q[%0d] got=%h want=%h", i, q, 4'(i)); end
      if (i == 0) begin
        compared++; if (wrfull !== 1'b0) begin mismatched++; $display("FAIL fill_read_wrfull got=%b want=0", wrfull); end
      end
    end
    rdreq = 1'b0;
    compared++; if (rdempty !== 1'b1) begin mismatched++; $display("FAIL fill_end_rdempty got=%b want=1", rdempty); end
    compared++; if (usedw !== 5'd0) begin mismatched++; $display("FAIL fill_end_usedw got=%0d want=0", usedw); end
  endtask

  task automatic test_empty_read;
    wrreq = 1'b1; data = 4'h7;
    @(negedge clock);
    wrreq = 1'b0; rdreq = 1'b1;
    @(negedge clock);
    compared++; if (q !== 4'h7) begin mismatched++; $display("FAIL empty_prime_q got=%h want=7", q); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      compared++; if (q !== 4'h7) begin mismatched++; $display("FAIL empty_read_q[%0d] got=%h want=7", c, q); end
      compared++; if (usedw !== 5'd0) begin mismatched++; $display("FAIL empty_read_usedw[%0d] got=%0d want=0", c, usedw); end
    end
    rdreq = 1'b0;
  endtask

  task automatic test_full_rw;
    wrreq = 1'b1; rdreq = 1'b0;
    for (int i = 0; i < 16; i++) begin
      data = 4'(15 - i);
      @(negedge clock);
    end
    compared++; if (wrfull !== 1'b1) begin mismatched++; $display("FAIL fullrw_pre_wrfull got=%b want=1", wrfull); end
    rdreq = 1'b1; data = 4'hC;
    @(negedge clock);
    compared++; if (q !== 4'hF) begin mismatched++; $display("FAIL fullrw_q got=%h want=f", q); end
    compared++; if (usedw !== 5'd15) begin mismatched++; $display("FAIL fullrw_usedw got=%0d want=15", usedw); end
    compared++; if (wrfull !== 1'b0) begin mismatched++; $display("FAIL fullrw_wrfull got=%b want=0", wrfull); end
    wrreq = 1'b0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clock);
      compared++; if (q !== 4'(15 - i)) begin mismatched++; $display("FAIL fullrw_drain_q[%0d] got=%h want=%h", i, q, 4'(15 - i)); end
    end
    rdreq = 1'b0;
    compared++; if (rdempty !== 1'b1) begin mismatched++; $display("FAIL fullrw_end_rdempty got=%b want=1", rdempty); end
  endtask

  task automatic test_reset_mid;
    wrreq = 1'b1; rdreq = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      data = 4'(i);
      @(negedge clock);
    end
    wrreq = 1'b0; rdreq = 1'b1;
    @(negedge clock);
    rdreq = 1'b0;
    compared++; if (q !== 4'h1) begin mismatched++; $display("FAIL mid_pre_q got=%h want=1", q); end
    compared++; if (usedw !== 5'd5) begin mismatched++; $display("FAIL mid_pre_usedw got=%0d want=5", usedw); end
    #1 aclr = 1'b1;
    #1;
    compared++; if (usedw !== 5'd0) begin mismatched++; $display("FAIL mid_usedw got=%0d want=0", usedw); end
    compared++; if (rdempty !== 1'b1) begin mismatched++; $display("FAIL mid_rdempty got=%b want=1", rdempty); end
    compared++; if (q !== 4'h0) begin mismatched++; $display("FAIL mid_q got=%h want=0", q); end
    #1 aclr = 1'b0;
    @(negedge clock);
    wrreq = 1'b1; data = 4'h9;
    @(negedge clock);
    compared++; if (usedw !== 5'd1) begin mismatched++; $display("FAIL mid_new_usedw got=%0d want=1", usedw); end
    wrreq = 1'b0; rdreq = 1'b1;
    @(negedge clock);
    rdreq = 1'b0;
    compared++; if (q !== 4'h9) begin mismatched++; $display("FAIL mid_new_q got=%h want=9", q); end
    compared++; if (rdempty !== 1'b1) begin mismatched++; $display("FAIL mid_new_rdempty got=%b want=1", rdempty); end
  endtask

  initial begin
    aclr = 1'b1; wrreq = 1'b1; rdreq = 1'b1; data = 4'h3;
    test_reset;
    test_streaming;
    test_fill;
    test_empty_read;
    test_full_rw;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
